// File: rtl/dmac_rd_req_arbiter.sv
// rtl/dmac_rd_req_arbiter.sv - round-robin read burst request arbiter with in-order response routing
module dmac_rd_req_arbiter #(
   parameter int CHANNEL_COUNT      = 8,
   parameter int ADDR_WD            = 32,
   parameter int RD_MAX_OUTSTANDING = 8,
   localparam int CH_WD = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [CHANNEL_COUNT-1:0]     ch_req_valid,
   input  logic [CHANNEL_COUNT*ADDR_WD-1:0] ch_req_addr,
   input  logic [CHANNEL_COUNT*2-1:0]   ch_req_burst,
   input  logic [CHANNEL_COUNT*ADDR_WD-1:0] ch_req_length,
   input  logic [CHANNEL_COUNT*3-1:0]   ch_req_size,
   output logic [CHANNEL_COUNT-1:0]     ch_req_ack,
   output logic [ADDR_WD-1:0]           ch_req_next_addr,
   output logic [ADDR_WD-1:0]           ch_req_next_length,
   output logic                         ch_req_done,
   output logic [CHANNEL_COUNT-1:0]     ch_resp_valid,
   output logic                         m_req_valid,
   output logic [ADDR_WD-1:0]           m_req_addr,
   output logic [1:0]                   m_req_burst,
   output logic [ADDR_WD-1:0]           m_req_length,
   output logic [2:0]                   m_req_size,
   input  logic                         m_req_ack,
   input  logic [ADDR_WD-1:0]           m_req_next_addr,
   input  logic [ADDR_WD-1:0]           m_req_next_length,
   input  logic                         m_req_done,
   input  logic                         m_resp_last,
   output logic [CH_WD-1:0]             grant_idx,
   output logic                         resp_underflow
);
   localparam int PTR_WD = (RD_MAX_OUTSTANDING > 1) ? $clog2(RD_MAX_OUTSTANDING) : 1;
   localparam int CNT_WD = $clog2(RD_MAX_OUTSTANDING + 1);

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   state_t            state;
   logic [CH_WD-1:0]  rr_ptr;
   logic [CH_WD-1:0]  sel_idx;
   logic [CH_WD-1:0]  cand;
   logic              sel_found;
   logic              granted;
   logic              accept;
   logic              pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CH_WD-1:0]  fifo_mem [RD_MAX_OUTSTANDING];
   logic [CH_WD-1:0]  fifo_head;
   logic [PTR_WD-1:0] wr_ptr;
   logic [PTR_WD-1:0] rd_ptr;
   logic [CNT_WD-1:0] fifo_cnt;

   // Scan downwards so the channel closest to rr_ptr overwrites any later one.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int k = CHANNEL_COUNT - 1; k >= 0; k--) begin
         cand = CH_WD'((int'(rr_ptr) + k) % CHANNEL_COUNT);
         if (ch_req_valid[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
   end

   assign granted    = (state == S_GRANT);
   assign fifo_full  = (fifo_cnt == CNT_WD'(RD_MAX_OUTSTANDING));
   assign fifo_empty = (fifo_cnt == '0);
   assign fifo_head  = fifo_mem[rd_ptr];

   assign m_req_valid  = granted && ch_req_valid[grant_idx] && !fifo_full;
   assign accept       = m_req_valid && m_req_ack;
   assign pop          = m_resp_last && !fifo_empty;

   assign m_req_addr   = granted ? ch_req_addr[int'(grant_idx)*ADDR_WD +: ADDR_WD] : '0;
   assign m_req_length = granted ? ch_req_length[int'(grant_idx)*ADDR_WD +: ADDR_WD] : '0;
   assign m_req_burst  = granted ? ch_req_burst[int'(grant_idx)*2 +: 2] : '0;
   assign m_req_size   = granted ? ch_req_size[int'(grant_idx)*3 +: 3] : '0;

   assign ch_req_ack         = accept ? (CHANNEL_COUNT'(1) << grant_idx) : '0;
   assign ch_resp_valid      = pop ? (CHANNEL_COUNT'(1) << fifo_head) : '0;
   assign ch_req_next_addr   = m_req_next_addr;
   assign ch_req_next_length = m_req_next_length;
   assign ch_req_done        = m_req_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         grant_idx <= '0;
         rr_ptr    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (sel_found) begin
                  grant_idx <= sel_idx;
                  state     <= S_GRANT;
               end
            end
            S_GRANT: begin
               if (accept) begin
                  rr_ptr <= (grant_idx == CH_WD'(CHANNEL_COUNT - 1)) ? '0 : grant_idx + 1'b1;
                  state  <= S_IDLE;
               end else if (!ch_req_valid[grant_idx]) begin
                  state <= S_IDLE;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         fifo_mem[wr_ptr] <= grant_idx;
      end
   end

   // Pointers wrap explicitly so non-power-of-two depths stay in range.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         fifo_cnt       <= '0;
         resp_underflow <= 1'b0;
      end else begin
         if (accept) begin
            wr_ptr <= (wr_ptr == PTR_WD'(RD_MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PTR_WD'(RD_MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + 1'b1;
         end
         case ({accept, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
         if (m_resp_last && fifo_empty) begin
            resp_underflow <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_dmac_rd_req_arbiter.sv
// tb/tb_dmac_rd_req_arbiter.sv - self-checking bench for dmac_rd_req_arbiter
module tb_dmac_rd_req_arbiter;
   localparam int N     = 8;
   localparam int AW    = 32;
   localparam int DEPTH = 4;
   localparam int CW    = 3;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    ch_req_valid;
   logic [N*AW-1:0] ch_req_addr;
   logic [N*2-1:0]  ch_req_burst;
   logic [N*AW-1:0] ch_req_length;
   logic [N*3-1:0]  ch_req_size;
   logic [N-1:0]    ch_req_ack;
   logic [AW-1:0]   ch_req_next_addr;
   logic [AW-1:0]   ch_req_next_length;
   logic            ch_req_done;
   logic [N-1:0]    ch_resp_valid;
   logic            m_req_valid;
   logic [AW-1:0]   m_req_addr;
   logic [1:0]      m_req_burst;
   logic [AW-1:0]   m_req_length;
   logic [2:0]      m_req_size;
   logic            m_req_ack;
   logic [AW-1:0]   m_req_next_addr;
   logic [AW-1:0]   m_req_next_length;
   logic            m_req_done;
   logic            m_resp_last;
   logic [CW-1:0]   grant_idx;
   logic            resp_underflow;

   int n_checks = 0;
   int n_fail   = 0;

   logic [N-1:0] exp_v;
   logic [N-1:0] exp_ack;
   logic [N-1:0] exp_resp;
   logic         exp_mv;
   int           n_acks;

   // Reference model: pending grant, rotation pointer, issue-order queue, sticky error
   bit m_have;
   int m_gnt;
   int m_rr;
   int m_q[$];
   bit m_uf;

   dmac_rd_req_arbiter #(
      .CHANNEL_COUNT(N), .ADDR_WD(AW), .RD_MAX_OUTSTANDING(DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .ch_req_valid(ch_req_valid), .ch_req_addr(ch_req_addr), .ch_req_burst(ch_req_burst),
      .ch_req_length(ch_req_length), .ch_req_size(ch_req_size),
      .ch_req_ack(ch_req_ack), .ch_req_next_addr(ch_req_next_addr),
      .ch_req_next_length(ch_req_next_length), .ch_req_done(ch_req_done),
      .ch_resp_valid(ch_resp_valid),
      .m_req_valid(m_req_valid), .m_req_addr(m_req_addr), .m_req_burst(m_req_burst),
      .m_req_length(m_req_length), .m_req_size(m_req_size),
      .m_req_ack(m_req_ack), .m_req_next_addr(m_req_next_addr),
      .m_req_next_length(m_req_next_length), .m_req_done(m_req_done),
      .m_resp_last(m_resp_last), .grant_idx(grant_idx), .resp_underflow(resp_underflow)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic init_inputs;
      ch_req_valid      = '0;
      ch_req_burst      = '0;
      ch_req_size       = '0;
      m_req_ack         = 1'b0;
      m_req_next_addr   = '0;
      m_req_next_length = '0;
      m_req_done        = 1'b0;
      m_resp_last       = 1'b0;
      for (int i = 0; i < N; i++) begin
         ch_req_addr[i*AW +: AW]   = 32'hA000_0000 + 32'(i) * 32'h100;
         ch_req_length[i*AW +: AW] = 32'(16 * (i + 1));
      end
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      init_inputs();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      m_have = 1'b0;
      m_gnt  = 0;
      m_rr   = 0;
      m_uf   = 1'b0;
      m_q.delete();
   endtask

   task automatic test_reset;
      rst_n = 1'b1;
      init_inputs();
      #2 rst_n = 1'b0;
      ch_req_valid = '1;
      tick();
      @(negedge clk);
      n_checks++;
      if ({m_req_valid, ch_req_ack, ch_resp_valid, resp_underflow} !== '0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got valid=%0b ack=%h resp=%h uf=%0b expected all 0",
                  m_req_valid, ch_req_ack, ch_resp_valid, resp_underflow);
      end
      n_checks++;
      if ({grant_idx, m_req_addr, m_req_length, m_req_burst, m_req_size} !== '0) begin
         n_fail++;
         $display("FAIL reset_fields: got gnt=%0d addr=%h len=%h expected 0", grant_idx, m_req_addr, m_req_length);
      end
   endtask

   task automatic test_single;
      do_reset();
      ch_req_valid = 8'h04;
      ch_req_addr[2*AW +: AW]   = 32'h1000;
      ch_req_length[2*AW +: AW] = 32'd64;
      ch_req_burst[4 +: 2]      = 2'b01;
      ch_req_size[6 +: 3]       = 3'd2;
      @(negedge clk);
      n_checks++;
      if (m_req_valid !== 1'b0) begin
         n_fail++; $display("FAIL single_latency: got m_req_valid=%0b expected 0", m_req_valid);
      end
      tick();
      @(negedge clk);
      n_checks++;
      if (m_req_valid !== 1'b1 || m_req_addr !== 32'h1000 || m_req_length !== 32'd64 ||
          m_req_burst !== 2'b01 || m_req_size !== 3'd2 || grant_idx !== 3'd2) begin
         n_fail++;
         $display("FAIL single_req: got v=%0b addr=%h len=%0d b=%0d s=%0d gnt=%0d expected 1 1000 64 1 2 2",
                  m_req_valid, m_req_addr, m_req_length, m_req_burst, m_req_size, grant_idx);
      end
      m_req_ack = 1'b1; m_req_next_addr = 32'h1040; m_req_done = 1'b1;
      #1;
      n_checks++;
      if (ch_req_ack !== 8'h04 || ch_req_next_addr !== 32'h1040 || ch_req_done !== 1'b1) begin
         n_fail++;
         $display("FAIL single_ack: got ack=%h next=%h done=%0b expected 04 1040 1", ch_req_ack, ch_req_next_addr, ch_req_done);
      end
      tick();
      ch_req_valid = '0; m_req_ack = 1'b0; m_req_done = 1'b0;
      @(negedge clk);
      n_checks++;
      if (ch_req_ack !== 8'h00 || m_req_valid !== 1'b0) begin
         n_fail++; $display("FAIL single_idle: got ack=%h valid=%0b expected 00 0", ch_req_ack, m_req_valid);
      end
      m_resp_last = 1'b1;
      #1;
      n_checks++;
      if (ch_resp_valid !== 8'h04) begin
         n_fail++; $display("FAIL single_resp: got %h expected 04", ch_resp_valid);
      end
      tick();
      m_resp_last = 1'b0;
   endtask

   task automatic test_fairness;
      do_reset();
      ch_req_valid = '1;
      m_req_ack    = 1'b1;
      for (int b = 0; b < 9; b++) begin
         @(negedge clk);
         n_checks++;
         if (m_req_valid !== 1'b0 || ch_req_ack !== 8'h00) begin
            n_fail++; $display("FAIL rr_gap[%0d]: got valid=%0b ack=%h expected 0 00", b, m_req_valid, ch_req_ack);
         end
         tick();
         m_resp_last = (b > 0);
         @(negedge clk);
         exp_v = '0; exp_v[b % N] = 1'b1;
         n_checks++;
         if (ch_req_ack !== exp_v || grant_idx !== CW'(b % N)) begin
            n_fail++; $display("FAIL rr_grant[%0d]: got ack=%h gnt=%0d expected %h %0d", b, ch_req_ack, grant_idx, exp_v, b % N);
         end
         exp_v = '0;
         if (b > 0) exp_v[(b - 1) % N] = 1'b1;
         n_checks++;
         if (ch_resp_valid !== exp_v) begin
            n_fail++; $display("FAIL rr_resp[%0d]: got %h expected %h", b, ch_resp_valid, exp_v);
         end
         tick();
         m_resp_last = 1'b0;
      end
   endtask

   task automatic test_outstanding;
      do_reset();
      ch_req_valid = 8'h01;
      m_req_ack    = 1'b1;
      n_acks       = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (ch_req_ack[0]) n_acks++;
         tick();
      end
      n_checks++;
      if (n_acks != DEPTH) begin
         n_fail++; $display("FAIL outst_acks: got %0d acks expected %0d", n_acks, DEPTH);
      end
      @(negedge clk);
      n_checks++;
      if (m_req_valid !== 1'b0 || grant_idx !== 3'd0) begin
         n_fail++; $display("FAIL outst_stall: got valid=%0b gnt=%0d expected 0 0", m_req_valid, grant_idx);
      end
      m_resp_last = 1'b1;
      #1;
      n_checks++;
      if (ch_resp_valid !== 8'h01 || m_req_valid !== 1'b0) begin
         n_fail++; $display("FAIL outst_pop: got resp=%h valid=%0b expected 01 0", ch_resp_valid, m_req_valid);
      end
      tick();
      m_resp_last = 1'b0;
      @(negedge clk);
      n_checks++;
      if (m_req_valid !== 1'b1 || ch_req_ack !== 8'h01) begin
         n_fail++; $display("FAIL outst_resume: got valid=%0b ack=%h expected 1 01", m_req_valid, ch_req_ack);
      end
      tick();
   endtask

   task automatic test_order;
      int ord_ch[3] = '{3, 1, 3};
      logic [N-1:0] ord_resp[2] = '{8'h02, 8'h08};
      do_reset();
      m_req_ack = 1'b1;
      for (int b = 0; b < 3; b++) begin
         ch_req_valid = '0;
         ch_req_valid[ord_ch[b]] = 1'b1;
         tick();
         m_resp_last = (b == 2);
         @(negedge clk);
         exp_v = '0; exp_v[ord_ch[b]] = 1'b1;
         n_checks++;
         if (ch_req_ack !== exp_v) begin
            n_fail++; $display("FAIL order_ack[%0d]: got %h expected %h", b, ch_req_ack, exp_v);
         end
         if (b == 2) begin
            n_checks++;
            if (ch_resp_valid !== 8'h08) begin
               n_fail++; $display("FAIL order_coincident: got %h expected 08", ch_resp_valid);
            end
         end
         tick();
         m_resp_last = 1'b0;
      end
      ch_req_valid = '0; m_req_ack = 1'b0; m_resp_last = 1'b1;
      for (int r = 0; r < 2; r++) begin
         @(negedge clk);
         n_checks++;
         if (ch_resp_valid !== ord_resp[r]) begin
            n_fail++; $display("FAIL order_resp[%0d]: got %h expected %h", r, ch_resp_valid, ord_resp[r]);
         end
         tick();
      end
      @(negedge clk);
      n_checks++;
      if (ch_resp_valid !== 8'h00) begin
         n_fail++; $display("FAIL order_empty: got %h expected 00", ch_resp_valid);
      end
      tick();
      m_resp_last = 1'b0;
      @(negedge clk);
      n_checks++;
      if (resp_underflow !== 1'b1) begin
         n_fail++; $display("FAIL order_uf: got %0b expected 1", resp_underflow);
      end
   endtask

   task automatic test_withdraw;
      do_reset();
      ch_req_valid = 8'h20;
      tick();
      @(negedge clk);
      n_checks++;
      if (m_req_valid !== 1'b1 || grant_idx !== 3'd5) begin
         n_fail++; $display("FAIL wd_grant: got valid=%0b gnt=%0d expected 1 5", m_req_valid, grant_idx);
      end
      tick();
      ch_req_valid = '0;
      @(negedge clk);
      n_checks++;
      if (m_req_valid !== 1'b0 || ch_req_ack !== 8'h00) begin
         n_fail++; $display("FAIL wd_drop: got valid=%0b ack=%h expected 0 00", m_req_valid, ch_req_ack);
      end
      tick();
      ch_req_valid = 8'h50;
      tick();
      @(negedge clk);
      n_checks++;
      if (grant_idx !== 3'd4 || m_req_valid !== 1'b1) begin
         n_fail++; $display("FAIL wd_rr_kept: got gnt=%0d valid=%0b expected 4 1", grant_idx, m_req_valid);
      end
      tick();
      ch_req_valid = '0;
      m_resp_last  = 1'b1;
      @(negedge clk);
      n_checks++;
      if (ch_resp_valid !== 8'h00) begin
         n_fail++; $display("FAIL wd_uf_resp: got %h expected 00", ch_resp_valid);
      end
      tick();
      m_resp_last = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      n_checks++;
      if (resp_underflow !== 1'b1) begin
         n_fail++; $display("FAIL wd_uf_sticky: got %0b expected 1", resp_underflow);
      end
   endtask

   task automatic test_async_reset;
      do_reset();
      ch_req_valid = 8'h02;
      m_req_ack    = 1'b1;
      repeat (6) tick();
      m_req_ack = 1'b0;
      tick();
      @(negedge clk);
      n_checks++;
      if (m_req_valid !== 1'b1 || grant_idx !== 3'd1) begin
         n_fail++; $display("FAIL arst_pre: got valid=%0b gnt=%0d expected 1 1", m_req_valid, grant_idx);
      end
      #1 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({m_req_valid, ch_req_ack, ch_resp_valid, resp_underflow, grant_idx, m_req_addr, m_req_length} !== '0) begin
         n_fail++;
         $display("FAIL arst_outputs: got valid=%0b ack=%h resp=%h uf=%0b gnt=%0d addr=%h expected all 0",
                  m_req_valid, ch_req_ack, ch_resp_valid, resp_underflow, grant_idx, m_req_addr);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      ch_req_valid = '0;
      m_resp_last  = 1'b1;
      @(negedge clk);
      n_checks++;
      if (ch_resp_valid !== 8'h00) begin
         n_fail++; $display("FAIL arst_fifo_empty: got %h expected 00", ch_resp_valid);
      end
      tick();
      m_resp_last = 1'b0;
      @(negedge clk);
      n_checks++;
      if (resp_underflow !== 1'b1) begin
         n_fail++; $display("FAIL arst_uf: got %0b expected 1", resp_underflow);
      end
   endtask

   task automatic test_random;
      do_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         ch_req_valid = ch_req_valid ^ (N'($urandom) & N'($urandom) & N'($urandom));
         for (int i = 0; i < N; i++) ch_req_addr[i*AW +: AW] = $urandom;
         m_req_ack       = 1'($urandom_range(0, 1));
         m_req_next_addr = $urandom;
         m_req_done      = 1'($urandom_range(0, 1));
         m_resp_last     = (m_q.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 60) == 0);

         exp_mv   = m_have && ch_req_valid[m_gnt] && (m_q.size() < DEPTH);
         exp_ack  = '0;
         if (exp_mv && m_req_ack) exp_ack[m_gnt] = 1'b1;
         exp_resp = '0;
         if (m_resp_last && m_q.size() > 0) exp_resp[m_q[0]] = 1'b1;

         @(negedge clk);
         n_checks++;
         if (m_req_valid !== exp_mv || ch_req_ack !== exp_ack || ch_resp_valid !== exp_resp) begin
            n_fail++;
            $display("FAIL rand_ctrl[%0d]: got v=%0b ack=%h resp=%h expected %0b %h %h",
                     cyc, m_req_valid, ch_req_ack, ch_resp_valid, exp_mv, exp_ack, exp_resp);
         end
         n_checks++;
         if (resp_underflow !== m_uf || ch_req_next_addr !== m_req_next_addr) begin
            n_fail++;
            $display("FAIL rand_misc[%0d]: got uf=%0b next=%h expected %0b %h", cyc, resp_underflow, ch_req_next_addr, m_uf, m_req_next_addr);
         end
         if (m_have) begin
            n_checks++;
            if (grant_idx !== CW'(m_gnt) || m_req_addr !== ch_req_addr[m_gnt*AW +: AW]) begin
               n_fail++;
               $display("FAIL rand_grant[%0d]: got gnt=%0d addr=%h expected %0d %h", cyc, grant_idx, m_req_addr, m_gnt, ch_req_addr[m_gnt*AW +: AW]);
            end
         end

         if (m_resp_last) begin
            if (m_q.size() > 0) void'(m_q.pop_front());
            else m_uf = 1'b1;
         end
         if (exp_mv && m_req_ack) begin
            m_q.push_back(m_gnt);
            m_rr   = (m_gnt + 1) % N;
            m_have = 1'b0;
         end else if (m_have) begin
            if (!ch_req_valid[m_gnt]) m_have = 1'b0;
         end else begin
            for (int k = 0; k < N; k++) begin
               if (!m_have && ch_req_valid[(m_rr + k) % N]) begin
                  m_gnt  = (m_rr + k) % N;
                  m_have = 1'b1;
               end
            end
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_outstanding();
      test_order();
      test_withdraw();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/dmac_rd_req_arbiter.md
Name: dmac_rd_req_arbiter

Overview:
Shares the single AXI read burst engine among CHANNEL_COUNT channel controllers.
- Grants one burst request at a time, round-robin.
- Routes the engine's ack/next-address/next-length/done results back to the granted channel.
- Records the issue order of bursts in an order FIFO, so each completed read burst's response pulse is routed to the channel that issued it (read responses return in order).

Parameters:
CHANNEL_COUNT, 8, number of requesting channels (>=2)
ADDR_WD, 32, address/length width
RD_MAX_OUTSTANDING, 8, order-FIFO depth = max read bursts in flight across all channels
CH_WD (localparam), max(1,$clog2(CHANNEL_COUNT)), channel index width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active low
ch_req_valid  in  CHANNEL_COUNT  per-channel read request valid
ch_req_addr  in  CHANNEL_COUNT*ADDR_WD  per-channel start address, channel i at [i*ADDR_WD +: ADDR_WD]
ch_req_burst  in  CHANNEL_COUNT*2  per-channel AXI burst type
ch_req_length  in  CHANNEL_COUNT*ADDR_WD  per-channel remaining length
ch_req_size  in  CHANNEL_COUNT*3  per-channel AXI size
ch_req_ack  out  CHANNEL_COUNT  one-hot ack pulse to granted channel
ch_req_next_addr  out  ADDR_WD  broadcast copy of m_req_next_addr
ch_req_next_length  out  ADDR_WD  broadcast copy of m_req_next_length
ch_req_done  out  1  broadcast copy of m_req_done
ch_resp_valid  out  CHANNEL_COUNT  one-hot burst-complete pulse
m_req_valid  out  1  request to burst engine
m_req_addr / m_req_burst / m_req_length / m_req_size  out  ADDR_WD/2/ADDR_WD/3  granted channel's fields
m_req_ack  in  1  engine accepted one burst
m_req_next_addr  in  ADDR_WD  address after accepted burst
m_req_next_length  in  ADDR_WD  remaining length after burst
m_req_done  in  1  accepted burst was the channel's last
m_resp_last  in  1  one read burst fully returned (RLAST beat)
grant_idx  out  CH_WD  current grant, debug
resp_underflow  out  1  sticky error flag

Behaviour:
- Reset (rst_n low, asynchronous) values:
  - all outputs 0
  - FSM=IDLE, rr_ptr=0
  - order FIFO empty
  - resp_underflow=0
- Mid-operation reset discards grant and FIFO contents.
- FSM IDLE: if any ch_req_valid, select the first set bit scanning rr_ptr, rr_ptr+1, ... modulo CHANNEL_COUNT. Register it into grant_idx, go GRANT. Otherwise stay.
- FSM GRANT:
  - m_req_valid = ch_req_valid[grant_idx] && !fifo_full.
  - m_req_* fields are muxed combinationally from grant_idx.
  - On m_req_valid && m_req_ack:
    - ch_req_ack[grant_idx]=1 for exactly that cycle.
    - Push grant_idx into the FIFO.
    - rr_ptr <= (grant_idx+1) mod CHANNEL_COUNT.
    - Go IDLE.
  - If ch_req_valid[grant_idx] deasserts before ack: go IDLE, no ack, rr_ptr unchanged.
- m_req_ack while m_req_valid=0 is ignored.
- ch_req_next_addr/next_length/done are combinational pass-throughs; they are meaningful only in the ch_req_ack cycle.
- Latency and throughput:
  - Request to m_req_valid: 1 cycle.
  - One burst per grant; max throughput is one accepted burst per 2 cycles.
- Fairness: with all channels requesting, grants rotate 0,1,...,N-1,0. A channel waits at most N-1 bursts.
- Order FIFO:
  - Depth RD_MAX_OUTSTANDING, width CH_WD; count width $clog2(RD_MAX_OUTSTANDING+1).
  - fifo_full stalls m_req_valid (held low, grant kept).
- Response routing:
  - On m_resp_last with FIFO non-empty: ch_resp_valid[head]=1 for one cycle (combinational from head), then pop.
  - Push and pop in the same cycle: count unchanged, both take effect. When full, a same-cycle pop does not unblock the push; the stall lifts the next cycle.
  - m_resp_last with FIFO empty: no ch_resp_valid, resp_underflow <= 1 (sticky until reset).
- Pointers wrap modulo depth. Non-power-of-2 depth must wrap explicitly.

Test Plan:
- Single request: ch2 valid, addr 0x1000, length 64 → m_req_valid 1 cycle later with addr 0x1000. Ack with next_addr 0x1040, done=1 → ch_req_ack=0b00000100 one cycle, ch_req_next_addr=0x1040, ch_req_done=1, FSM IDLE.
- All 8 channels continuously valid, engine acks immediately → grant sequence 0..7,0 with 2-cycle spacing; each ch_req_ack one-hot.
- Outstanding limit: RD_MAX_OUTSTANDING=4, ch0 requesting, no m_resp_last → exactly 4 acks, then m_req_valid stays 0. One m_resp_last → ch_resp_valid[0]=1, next cycle m_req_valid=1.
- Response order: issue bursts for ch3, ch1, ch3, then pulse m_resp_last 3 times → ch_resp_valid = 0x08, 0x02, 0x08 in order. m_resp_last coincident with an ack → count unchanged.
- Withdraw: ch5 granted, drops valid before ack → no ch_req_ack, IDLE, rr_ptr unchanged. m_resp_last with FIFO empty → resp_underflow=1, stays 1.
- Async reset asserted mid-GRANT with 3 bursts in FIFO → all outputs 0 immediately. After release, m_resp_last raises resp_underflow (FIFO empty).
